// File: rtl/nebula_pkg.sv
// Shared types and defaults for the nebula weighted round-robin arbiter.
package nebula_pkg;

    localparam int ARB_WEIGHT_W = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_lock_state_e;

endpackage

// File: rtl/nebula_rr_pick.sv
// Cyclic first-one search starting at start_i: the request vector is doubled and
// the bits below start_i are masked off, so the lowest surviving bit is the winner.
module nebula_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] start_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] id_o,
    output logic            valid_o
);

    logic [2*N-1:0] mask;
    logic [2*N-1:0] dbl_req;

    assign mask    = {(2*N){1'b1}} << start_i;
    assign dbl_req = {req_i, req_i} & mask;

    always_comb begin
        int hit_idx;
        int win;
        logic hit_any;
        grant_o = '0;
        id_o    = '0;
        valid_o = 1'b0;
        hit_any = 1'b0;
        hit_idx = 0;
        win     = 0;
        for (int k = 2*N-1; k >= 0; k--) begin
            if (dbl_req[k]) begin
                hit_any = 1'b1;
                hit_idx = k;
            end
        end
        if (hit_any) begin
            win          = (hit_idx >= N) ? (hit_idx - N) : hit_idx;
            grant_o[win] = 1'b1;
            id_o         = ID_W'(win);
            valid_o      = 1'b1;
        end
    end

endmodule

// File: rtl/nebula_wrr_arbiter.sv
// N-way weighted round-robin arbiter with head-to-tail packet locking.
// Grant is combinational from state and req; state advances only on transfers.
module nebula_wrr_arbiter
    import nebula_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int WEIGHT_W = ARB_WEIGHT_W,
    parameter int LOCK_EN  = 1,
    parameter int ID_W     = $clog2(NUM_REQS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQS-1:0]          req,
    input  logic [NUM_REQS-1:0]          req_last,
    input  logic [NUM_REQS*WEIGHT_W-1:0] weight,
    input  logic                         accept,
    output logic [NUM_REQS-1:0]          grant,
    output logic                         grant_valid,
    output logic [ID_W-1:0]              grant_id,
    output logic                         locked
);

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [WEIGHT_W-1:0] cnt_q, cnt_d;
    arb_lock_state_e     lock_q, lock_d;
    logic [ID_W-1:0]     owner_q, owner_d;

    logic [WEIGHT_W-1:0] weight_arr [NUM_REQS];
    logic [NUM_REQS-1:0] last_eff;
    logic [NUM_REQS-1:0] owner_oh;
    logic [NUM_REQS-1:0] pick_grant;
    logic [ID_W-1:0]     pick_id;
    logic                pick_valid;
    logic                transfer;
    logic                is_tail;
    logic [WEIGHT_W:0]   eff_weight;
    logic [WEIGHT_W:0]   served_n;
    logic [ID_W-1:0]     ptr_after;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_weight
            assign weight_arr[gi] = weight[gi*WEIGHT_W +: WEIGHT_W];
            // Without locking every flit is treated as a complete packet.
            assign last_eff[gi]   = (LOCK_EN != 0) ? req_last[gi] : 1'b1;
        end
    endgenerate

    nebula_rr_pick #(
        .N    (NUM_REQS),
        .ID_W (ID_W)
    ) u_pick (
        .req_i   (req),
        .start_i (ptr_q),
        .grant_o (pick_grant),
        .id_o    (pick_id),
        .valid_o (pick_valid)
    );

    assign owner_oh = NUM_REQS'(1) << owner_q;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        if (lock_q == ARB_LOCKED) begin
            grant = owner_oh & req;
            if (req[owner_q]) begin
                grant_id = owner_q;
            end
        end else if (pick_valid) begin
            grant    = pick_grant;
            grant_id = pick_id;
        end
    end

    assign grant_valid = |grant;
    assign locked      = (lock_q == ARB_LOCKED);
    assign transfer    = grant_valid & accept;
    assign is_tail     = last_eff[grant_id];

    // Weight 0 behaves as 1; the compare is one bit wider so cnt cannot wrap.
    assign eff_weight = (weight_arr[grant_id] == '0) ? (WEIGHT_W+1)'(1)
                                                    : {1'b0, weight_arr[grant_id]};
    assign served_n   = (grant_id == ptr_q) ? ({1'b0, cnt_q} + (WEIGHT_W+1)'(1))
                                            : (WEIGHT_W+1)'(1);
    assign ptr_after  = (grant_id == ID_W'(NUM_REQS-1)) ? '0 : (grant_id + ID_W'(1));

    always_comb begin
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lock_d  = lock_q;
        owner_d = owner_q;
        if (transfer) begin
            if (is_tail) begin
                lock_d = ARB_IDLE;
                if (served_n >= eff_weight) begin
                    ptr_d = ptr_after;
                    cnt_d = '0;
                end else begin
                    ptr_d = grant_id;
                    cnt_d = served_n[WEIGHT_W-1:0];
                end
            end else if (lock_q == ARB_IDLE) begin
                lock_d  = ARB_LOCKED;
                owner_d = grant_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            lock_q  <= ARB_IDLE;
            owner_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

`ifdef ASSERT_ON
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_subset: assert property (@(posedge clk) disable iff (!rst_n) (grant & ~req) == '0);
    a_owner:  assert property (@(posedge clk) disable iff (!rst_n)
                               locked |-> ((grant & ~owner_oh) == '0));
    a_id:     assert property (@(posedge clk) disable iff (!rst_n) int'(grant_id) < NUM_REQS);
`endif

endmodule

// File: tb/tb_nebula_wrr_arbiter.sv
// Directed and randomized bench for nebula_wrr_arbiter against a behavioural
// model of pointer, served-count and packet lock kept as plain integers.
module tb_nebula_wrr_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] req_last;
    logic [15:0]  w;
    logic         accept;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic [1:0]   grant_id;
    logic         locked;

    int vectors;
    int miscompares;

    int m_ptr, m_cnt, m_owner;
    bit m_locked;
    bit xfer_v;
    int xfer_id;

    nebula_wrr_arbiter #(
        .NUM_REQS (N),
        .WEIGHT_W (4),
        .LOCK_EN  (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_last    (req_last),
        .weight      (w),
        .accept      (accept),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_owner = 0; m_locked = 0;
    endtask

    // Expected grant: owner only while mid-packet, otherwise first requester from ptr.
    task automatic model_eval(input logic [N-1:0] r, output logic [N-1:0] g, output int id);
        bit found;
        g = '0; id = 0; found = 0;
        if (m_locked) begin
            if (r[m_owner]) begin g[m_owner] = 1'b1; id = m_owner; end
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (!found && r[j]) begin found = 1; g[j] = 1'b1; id = j; end
            end
        end
    endtask

    task automatic model_update(input logic [N-1:0] l, input bit xv, input int id);
        int ew, n;
        if (!xv) return;
        if (l[id]) begin
            m_locked = 0;
            ew = (w[id*4 +: 4] == 0) ? 1 : int'(w[id*4 +: 4]);
            n  = (id == m_ptr) ? m_cnt + 1 : 1;
            if (n >= ew) begin m_ptr = (id + 1) % N; m_cnt = 0; end
            else begin m_ptr = id; m_cnt = n; end
        end else if (!m_locked) begin
            m_locked = 1; m_owner = id;
        end
    endtask

    // One cycle: drive at the falling edge, check mid-phase, update model at the rising edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic a, input int exp_id);
        logic [N-1:0] eg;
        int eid;
        req = r; req_last = l; accept = a;
        #1;
        model_eval(r, eg, eid);
        chk("grant", 32'(grant), 32'(eg));
        chk("grant_valid", 32'(grant_valid), 32'(eg != '0));
        chk("grant_id", 32'(grant_id), 32'(eid));
        chk("locked", 32'(locked), 32'(m_locked));
        if (exp_id >= 0) begin
            chk("directed_id", 32'(grant_id), 32'(exp_id));
        end
        xfer_v  = (eg != '0) && a;
        xfer_id = eid;
        @(posedge clk);
        model_update(l, xfer_v, xfer_id);
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] p_req, p_last;
        int seq_w [8];
        vectors = 0; miscompares = 0;
        model_reset();
        rst_n = 1'b0; req = '0; req_last = '0; accept = 1'b0; w = 16'h1111;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_id", 32'(grant_id), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Equal weights, all requesting single flits: plain rotation.
        for (int i = 0; i < 8; i++) step(4'b1111, 4'b1111, 1'b1, i % 4);

        // Requestor 3 weighted 3 against requestor 0 weighted 1.
        w = {4'd3, 4'd1, 4'd1, 4'd1};
        seq_w = '{0, 3, 3, 3, 0, 3, 3, 3};
        for (int i = 0; i < 8; i++) step(4'b1001, 4'b1001, 1'b1, seq_w[i]);
        w = 16'h1111;

        // Three-flit packet from requestor 1 while requestor 2 waits.
        step(4'b0110, 4'b0100, 1'b1, 1);
        step(4'b0110, 4'b0100, 1'b1, 1);
        step(4'b0110, 4'b0110, 1'b1, 1);
        step(4'b0100, 4'b0100, 1'b1, 2);

        // Owner drops request mid-packet: nobody else may be granted.
        step(4'b0110, 4'b0100, 1'b1, 1);
        step(4'b0100, 4'b0100, 1'b1, -1);
        chk("drop_grant0", 32'(grant), 32'h0);
        step(4'b0100, 4'b0100, 1'b1, -1);
        step(4'b0110, 4'b0110, 1'b1, 1);
        step(4'b0100, 4'b0100, 1'b1, 2);

        // Backpressure: grant holds until the first accept.
        for (int i = 0; i < 5; i++) step(4'b0110, 4'b0110, 1'b0, 1);
        step(4'b0110, 4'b0110, 1'b1, 1);

        // Asynchronous reset in the middle of a packet owned by requestor 2.
        step(4'b0100, 4'b0000, 1'b1, 2);
        chk("pre_rst_locked", 32'(locked), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_locked", 32'(locked), 32'h0);
        req = '0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'h0);
        chk("async_rst_valid", 32'(grant_valid), 32'h0);
        chk("async_rst_id", 32'(grant_id), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1100, 4'b1100, 1'b1, 2);

        // Randomized traffic: each requestor holds its flit until it transfers.
        p_req = '0; p_last = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 40) == 0) w = 16'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!p_req[i] && $urandom_range(0, 1) == 1) begin
                    p_req[i]  = 1'b1;
                    p_last[i] = ($urandom_range(0, 2) != 0);
                end
            end
            step(p_req, p_last, ($urandom_range(0, 3) != 0), -1);
            if (xfer_v) begin
                p_req[xfer_id]  = 1'b0;
                p_last[xfer_id] = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
